// File: rtl/mod7879_byte_decoder.sv
// Streaming big-endian byte decoder returning the centered residue mod 7879.
// Horner accumulation, one byte per cycle, valid/ready on both sides.
module mod7879_byte_decoder #(
  parameter int Q  = 7879,
  parameter int QH = 3939
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [12:0] Out
);

  localparam logic [29:0] RECIP = 30'((64'd1 << 21) / 64'(Q));
  localparam logic [20:0] Q21 = 21'(Q);
  localparam logic [14:0] Q15 = 15'(Q);
  localparam logic [12:0] Q13 = 13'(Q);
  localparam logic [12:0] QH13 = 13'(QH);

  logic [12:0] acc;
  logic        accept;
  logic [20:0] x;
  logic [29:0] prod;
  logic [8:0]  q;
  logic [20:0] r0;
  logic [14:0] r1;
  logic [14:0] r2;
  logic [12:0] r;
  logic [12:0] cent;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // The reciprocal quotient undershoots by at most 2, so two
  // conditional subtractions land the remainder in [0, Q-1].
  always_comb begin
    x    = {acc, 8'h00} + {13'd0, in_data};
    prod = {9'd0, x} * RECIP;
    q    = prod[29:21];
    r0   = x - ({12'd0, q} * Q21);
    r1   = r0[14:0];
    if (r1 >= Q15) r1 = r1 - Q15;
    r2   = r1;
    if (r2 >= Q15) r2 = r2 - Q15;
    r    = r2[12:0];
    cent = (r > QH13) ? (r - Q13) : r;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
      Out       <= '0;
    end else begin
      if (accept) begin
        if (in_last) begin
          acc <= '0;
          Out <= signed'(cent);
        end else begin
          acc <= r;
        end
      end
      if (accept && in_last)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod7879_byte_decoder.sv
// Self-checking bench for mod7879_byte_decoder: directed cases plus
// random 36-bit frames scored against an arithmetic reference.
module tb_mod7879_byte_decoder;

  logic              clk = 1'b0;
  logic              Reset;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [12:0] Out;

  int n_checks = 0;
  int n_errors = 0;
  bit rnd_rdy = 1'b0;
  int n_xfer = 0;
  int exp_q[$];

  mod7879_byte_decoder dut (
    .clk(clk),
    .Reset(Reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int center(input longint unsigned v);
    int r;
    r = int'(v % 64'd7879);
    return (r > 3939) ? r - 7879 : r;
  endfunction

  // Scoreboard: each output transfer must match the oldest expected value.
  always @(negedge clk) begin
    if (!Reset && out_valid && out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", int'(Out), 99999);
      end else begin
        chk("scoreboard", int'(Out), exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
  endtask

  initial begin
    longint unsigned v;
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(Out), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    tick();

    // Single byte, one-cycle latency, then out_valid drops.
    exp_q.push_back(255);
    send_byte(8'hFF, 1'b1);
    idle();
    chk("single_valid", int'(out_valid), 1);
    chk("single_out", int'(Out), 255);
    tick();
    chk("single_drop", int'(out_valid), 0);

    // Boundaries around Q and QH.
    exp_q.push_back(0);
    send_byte(8'h1E, 1'b0);
    send_byte(8'hC7, 1'b1);
    idle();
    chk("q_val", int'(Out), 0);
    exp_q.push_back(3939);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h63, 1'b1);
    idle();
    chk("qh_val", int'(Out), 3939);
    exp_q.push_back(-3939);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h64, 1'b1);
    idle();
    chk("qh1_val", int'(Out), -3939);
    tick();

    // 2^32-1 twice back to back.
    n_xfer = 0;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(-1669);
      for (int k = 0; k < 4; k++) send_byte(8'hFF, k == 3);
      chk("ffff_out", int'(Out), -1669);
      chk("ffff_valid", int'(out_valid), 1);
    end
    idle();
    tick();
    chk("ffff_count", n_xfer, 2);

    // Backpressure: result held, input stalled, then same-cycle resume.
    out_ready = 1'b0;
    exp_q.push_back(7);
    send_byte(8'h07, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h09;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_out", int'(Out), 7);
    end
    tick();
    out_ready = 1'b1;
    exp_q.push_back(9);
    @(negedge clk);
    chk("bp_resume", int'(in_ready), 1);
    tick();
    idle();
    chk("bp_new_valid", int'(out_valid), 1);
    chk("bp_new_out", int'(Out), 9);
    tick();

    // Reset mid-frame discards the partial integer.
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.push_back(5);
    send_byte(8'h05, 1'b1);
    idle();
    chk("rst_mid_out", int'(Out), 5);
    tick();

    // Random 36-bit frames with input gaps and random consumer stalls.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      v = {32'($urandom), 32'($urandom)};
      v = v & 64'hF_FFFF_FFFF;
      if (f == 0) v = 64'hF_FFFF_FFFF;
      if (f == 1) v = 64'd0;
      exp_q.push_back(center(v));
      for (int k = 4; k >= 0; k--) begin
        if ($urandom_range(0, 2) == 0) begin
          idle();
          repeat ($urandom_range(1, 3)) tick();
        end
        send_byte(8'(v >> (8 * k)), k == 0);
      end
    end
    idle();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) tick();
    chk("drain", exp_q.size(), 0);
    rnd_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
